cnn_div_23s_14s_9s: RTL and testbench

CNN_DIV_23S_14S_9S -- requirements
Module: cnn_div_23s_14s_9s

---
 rtl/cnn_div_pkg.sv | 21 ++
 rtl/cnn_div_23s_14s_9s_step.sv | 29 ++
 rtl/cnn_div_23s_14s_9s.sv | 157 +++++++++++++++
 tb/tb_cnn_div_23s_14s_9s.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_div_pkg.sv
// Shared definitions for the cnn_div_23s_14s_9s signed divider.
//   state_t         : sequencing states of the divider FSM
//   *_WIDTH_DEF     : default operand / result widths (23 / 14 / 9)
//   QMAX / QMIN     : clamp bounds of the signed quotient
package cnn_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DIN0_WIDTH_DEF = 23;
  localparam int DIN1_WIDTH_DEF = 14;
  localparam int DOUT_WIDTH_DEF = 9;

  localparam int QMAX = 255;
  localparam int QMIN = -256;

endpackage

// File: rtl/cnn_div_23s_14s_9s_step.sv
// One restoring division step on unsigned magnitudes.
//   rem_in  : current partial remainder (always < divisor when divisor != 0)
//   bit_in  : next dividend bit, shifted in at the LSB
//   divisor : divisor magnitude
//   rem_out : new partial remainder
//   q_bit   : quotient bit produced by this step
module cnn_div_23s_14s_9s_step #(
  parameter int W = 14
) (
  input  logic [W-1:0] rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0]   shifted;
  logic [W-1:0] diff;

  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {1'b0, divisor});
    // When the subtraction succeeds the true difference is below the divisor,
    // so the low W bits hold it exactly.
    diff    = shifted[W-1:0] - divisor;
    rem_out = q_bit ? diff : shifted[W-1:0];
  end

endmodule

// File: rtl/cnn_div_23s_14s_9s.sv
// Multi-cycle signed divider: din0 / din1, quotient clamped to dout_WIDTH bits.
//   ap_clk, ap_rst      : clock, asynchronous active-high reset
//   ap_start / ap_ready : request / combinational accept pulse (IDLE only)
//   ap_idle, ap_done    : in IDLE / one-cycle result-valid pulse
//   din0, din1          : signed dividend / divisor, captured on accept
//   dout, rem           : signed quotient (truncated toward zero) / remainder
//   sat, dbz            : quotient clamped / divisor was zero
//
// state | meaning
// IDLE  | waiting for ap_start, operands captured on accept
// CALC  | din0_WIDTH restoring steps, one per cycle
// FIX   | apply signs, clamp, handle divide-by-zero
// DONE  | results registered, ap_done high for this one cycle
module cnn_div_23s_14s_9s
  import cnn_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = DIN0_WIDTH_DEF,
  parameter int din1_WIDTH = DIN1_WIDTH_DEF,
  parameter int dout_WIDTH = DOUT_WIDTH_DEF
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  sat,
  output logic                  dbz
);

  localparam int unused_id = ID;

  localparam int                    CW       = $clog2(din0_WIDTH);
  localparam logic [CW-1:0]         last_cnt = CW'(din0_WIDTH - 1);
  localparam logic [din0_WIDTH-1:0] pos_lim  = din0_WIDTH'(QMAX);
  localparam logic [din0_WIDTH-1:0] neg_lim  = din0_WIDTH'(-QMIN);
  localparam logic [dout_WIDTH-1:0] q_max    = dout_WIDTH'(QMAX);
  localparam logic [dout_WIDTH-1:0] q_min    = dout_WIDTH'(QMIN);

  state_t state, state_nxt;

  logic [CW-1:0]         cnt;
  // Dividend magnitude shifts out of the top while quotient bits shift in at
  // the bottom; after the last step it holds the quotient magnitude.
  logic [din0_WIDTH-1:0] a_q;
  logic [din1_WIDTH-1:0] r_q;
  logic [din1_WIDTH-1:0] d_mag;
  logic                  s0, s1;

  logic [din1_WIDTH-1:0] r_nxt;
  logic                  q_bit;

  logic                  neg;
  logic [dout_WIDTH-1:0] q_trunc;
  logic [dout_WIDTH-1:0] fix_dout;
  logic [din1_WIDTH-1:0] fix_rem;
  logic                  fix_sat;
  logic                  fix_dbz;

  cnn_div_23s_14s_9s_step #(.W(din1_WIDTH)) u_step (
    .rem_in  (r_q),
    .bit_in  (a_q[din0_WIDTH-1]),
    .divisor (d_mag),
    .rem_out (r_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ap_start) state_nxt = CALC;
      CALC:    if (cnt == last_cnt) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ap_ready is masked during reset so it reads 0 even with ap_start high.
  assign ap_ready = (state == IDLE) && ap_start && !ap_rst;
  assign ap_idle  = (state == IDLE);
  assign ap_done  = (state == DONE);

  always_comb begin
    neg      = s0 ^ s1;
    q_trunc  = a_q[dout_WIDTH-1:0];
    fix_dout = neg ? -q_trunc : q_trunc;
    fix_rem  = s0 ? -r_q : r_q;
    fix_sat  = 1'b0;
    fix_dbz  = 1'b0;
    if (d_mag == '0) begin
      fix_dbz  = 1'b1;
      fix_sat  = 1'b1;
      fix_rem  = '0;
      fix_dout = s0 ? q_min : q_max;
    end else if (!neg && (a_q > pos_lim)) begin
      fix_sat  = 1'b1;
      fix_dout = q_max;
    end else if (neg && (a_q > neg_lim)) begin
      fix_sat  = 1'b1;
      fix_dout = q_min;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      cnt   <= '0;
      a_q   <= '0;
      r_q   <= '0;
      d_mag <= '0;
      s0    <= 1'b0;
      s1    <= 1'b0;
      dout  <= '0;
      rem   <= '0;
      sat   <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ap_start) begin
            s0    <= din0[din0_WIDTH-1];
            s1    <= din1[din1_WIDTH-1];
            // Unsigned magnitudes: negating the most negative value yields
            // its exact magnitude in the same width.
            a_q   <= din0[din0_WIDTH-1] ? -din0 : din0;
            d_mag <= din1[din1_WIDTH-1] ? -din1 : din1;
            r_q   <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          a_q <= {a_q[din0_WIDTH-2:0], q_bit};
          r_q <= r_nxt;
          cnt <= (cnt == last_cnt) ? '0 : cnt + CW'(1);
        end
        FIX: begin
          dout <= fix_dout;
          rem  <= fix_rem;
          sat  <= fix_sat;
          dbz  <= fix_dbz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_div_23s_14s_9s.sv
module tb_cnn_div_23s_14s_9s;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_idle;
  logic        ap_done;
  logic [22:0] din0;
  logic [13:0] din1;
  logic [8:0]  dout;
  logic [13:0] rem;
  logic        sat;
  logic        dbz;

  int tests = 0;
  int fails = 0;

  always #5 ap_clk = ~ap_clk;

  cnn_div_23s_14s_9s dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .ap_start (ap_start),
    .ap_ready (ap_ready),
    .ap_idle  (ap_idle),
    .ap_done  (ap_done),
    .din0     (din0),
    .din1     (din1),
    .dout     (dout),
    .rem      (rem),
    .sat      (sat),
    .dbz      (dbz)
  );

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    bit s;
    bit z;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference: plain signed arithmetic (truncating division, remainder with
  // the dividend's sign), then clamp.
  function automatic void model(input int a, input int b,
                                output int q, output int r,
                                output bit s, output bit z);
    longint qq;
    s = 1'b0;
    z = 1'b0;
    if (b == 0) begin
      z = 1'b1;
      s = 1'b1;
      r = 0;
      q = (a >= 0) ? 255 : -256;
    end else begin
      qq = longint'(a) / longint'(b);
      r  = a % b;
      if (qq > 255) begin
        q = 255;
        s = 1'b1;
      end else if (qq < -256) begin
        q = -256;
        s = 1'b1;
      end else begin
        q = int'(qq);
      end
    end
  endfunction

  // Issue one request from IDLE and check handshake, latency, output hold
  // while busy, results and the single-cycle done pulse.
  task automatic do_op(input int a, input int b, input int eq, input int er,
                       input bit es, input bit ez, input string tag);
    logic [8:0]  od;
    logic [13:0] orr;
    logic        os, oz;
    bit          hold_ok;
    bit          seen;
    int          lat;
    od = dout; orr = rem; os = sat; oz = dbz;
    hold_ok = 1'b1;
    seen = 1'b0;
    lat = -1;
    din0 = a[22:0];
    din1 = b[13:0];
    ap_start = 1'b1;
    #1;
    chk({tag, " ready"}, ap_ready, 1);
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    din0 = 23'($urandom());
    din1 = 14'($urandom());
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(posedge ap_clk); #1;
      if (ap_done) begin
        seen = 1'b1;
        lat = k + 1;
      end else if (dout !== od || rem !== orr || sat !== os || dbz !== oz || ap_ready !== 1'b0) begin
        hold_ok = 1'b0;
      end
    end
    chk({tag, " latency"}, lat, 25);
    chk({tag, " hold"}, hold_ok, 1);
    chk({tag, " dout"}, $signed(dout), eq);
    chk({tag, " rem"}, $signed(rem), er);
    chk({tag, " sat"}, sat, es);
    chk({tag, " dbz"}, dbz, ez);
    @(posedge ap_clk); #1;
    chk({tag, " done_pulse"}, ap_done, 0);
    chk({tag, " idle_after"}, ap_idle, 1);
  endtask

  initial begin
    int done_c[$];
    int rdy_c[$];
    int ndone;
    int done_at;
    bit rdy_bad;

    vecs.push_back('{1000, 7, 142, 6, 1'b0, 1'b0});
    vecs.push_back('{-1000, 7, -142, -6, 1'b0, 1'b0});
    vecs.push_back('{1000, -7, -142, 6, 1'b0, 1'b0});
    vecs.push_back('{100000, 3, 255, 1, 1'b1, 1'b0});
    vecs.push_back('{-4194304, -8192, 255, 0, 1'b1, 1'b0});
    vecs.push_back('{5, 0, 255, 0, 1'b1, 1'b1});
    vecs.push_back('{-5, 0, -256, 0, 1'b1, 1'b1});
    vecs.push_back('{0, 0, 255, 0, 1'b1, 1'b1});
    vecs.push_back('{255, 1, 255, 0, 1'b0, 1'b0});
    vecs.push_back('{256, 1, 255, 0, 1'b1, 1'b0});
    vecs.push_back('{-256, 1, -256, 0, 1'b0, 1'b0});
    vecs.push_back('{-257, 1, -256, 0, 1'b1, 1'b0});
    vecs.push_back('{0, 5, 0, 0, 1'b0, 1'b0});
    vecs.push_back('{-7, 7, -1, 0, 1'b0, 1'b0});
    vecs.push_back('{4194303, 8191, 255, 511, 1'b1, 1'b0});
    vecs.push_back('{8191, -8192, 0, 8191, 1'b0, 1'b0});
    vecs.push_back('{-4194304, 1, -256, 0, 1'b1, 1'b0});

    // Reset state, with ap_start high to confirm ap_ready stays low.
    ap_rst = 1'b1;
    ap_start = 1'b1;
    din0 = '0;
    din1 = '0;
    #12;
    chk("rst dout", dout, 0);
    chk("rst rem", rem, 0);
    chk("rst sat", sat, 0);
    chk("rst dbz", dbz, 0);
    chk("rst done", ap_done, 0);
    chk("rst ready", ap_ready, 0);
    chk("rst idle", ap_idle, 1);
    ap_start = 1'b0;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;

    for (int i = 0; i < vecs.size(); i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].s, vecs[i].z,
            $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      logic signed [22:0] ra;
      logic signed [13:0] rb;
      int a, b, q, r;
      bit s, z;
      ra = 23'($urandom());
      rb = 14'($urandom());
      a = int'(ra);
      b = int'(rb);
      if (i % 2 == 0) a = a % 4000;
      if (i % 4 == 1) b = b % 20;
      if (i % 8 == 3) b = 0;
      model(a, b, q, r, s, z);
      do_op(a, b, q, r, s, z, $sformatf("rnd%0d(%0d/%0d)", i, a, b));
    end

    // ap_start pulsed during CALC must be ignored.
    din0 = 23'd1000;
    din1 = 14'd7;
    ap_start = 1'b1;
    #1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    ndone = 0;
    done_at = -1;
    rdy_bad = 1'b0;
    for (int c = 2; c <= 60; c++) begin
      @(posedge ap_clk); #1;
      if (ap_done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (c == 10) begin
        ap_start = 1'b1;
        din0 = 23'd2000;
        din1 = 14'd3;
        #1;
        if (ap_ready) rdy_bad = 1'b1;
      end
      if (c == 11) ap_start = 1'b0;
    end
    chk("ign ready", rdy_bad, 0);
    chk("ign ndone", ndone, 1);
    chk("ign done_at", done_at, 25);
    chk("ign dout", $signed(dout), 142);
    chk("ign rem", $signed(rem), 6);

    // Reset in the middle of CALC discards the request.
    din0 = 23'd1000;
    din1 = 14'd7;
    ap_start = 1'b1;
    #1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    ndone = 0;
    for (int c = 2; c <= 60; c++) begin
      @(posedge ap_clk); #1;
      if (ap_done) ndone++;
      if (c == 12) begin
        ap_rst = 1'b1;
        #1;
        chk("mrst dout", dout, 0);
        chk("mrst rem", rem, 0);
        chk("mrst sat", sat, 0);
        chk("mrst dbz", dbz, 0);
        chk("mrst idle", ap_idle, 1);
        chk("mrst done", ap_done, 0);
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
      end
    end
    chk("mrst no_done", ndone, 0);
    do_op(1000, 7, 142, 6, 1'b0, 1'b0, "after_rst");

    // Back-to-back with ap_start held: next accept right after DONE.
    din0 = 23'd1000;
    din1 = 14'd7;
    ap_start = 1'b1;
    #1;
    if (ap_ready) rdy_c.push_back(0);
    for (int c = 1; c <= 60; c++) begin
      @(posedge ap_clk); #1;
      if (c == 27) ap_start = 1'b0;
      #1;
      if (ap_done) done_c.push_back(c);
      if (ap_ready) rdy_c.push_back(c);
    end
    chk("b2b ndone", done_c.size(), 2);
    chk("b2b done0", (done_c.size() > 0) ? done_c[0] : -1, 25);
    chk("b2b done1", (done_c.size() > 1) ? done_c[1] : -1, 51);
    chk("b2b nready", rdy_c.size(), 2);
    chk("b2b ready1", (rdy_c.size() > 1) ? rdy_c[1] : -1, 26);
    chk("b2b dout", $signed(dout), 142);
    chk("b2b rem", $signed(rem), 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
